load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 17, byte-address width of the data memory.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have req_valid  input  1  core load/store request.
REQ-006 SHALL have req_ready  output  1  unit can accept a request.
REQ-007 SHALL have req_we  input  1  1=store, 0=load.
REQ-008 SHALL have address_mode  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 SHALL have req_addr  input  WIDTH  byte address; req_wdata  input  WIDTH  store data, right-justified.
REQ-011 SHALL have rsp_valid  output  1  one-cycle completion pulse; rsp_rdata  output  WIDTH  load result; rsp_err  output  1  access fault.
REQ-012 SHALL have mem_req  output  1; mem_we  output  1; mem_addr  output  ADDR_W  word-aligned (bits[1:0]=0); mem_be  output  4  byte enables; mem_wdata  output  WIDTH.
REQ-013 SHALL have mem_ack  input  1  memory completed current beat; mem_rdata  input  WIDTH  read word, valid with mem_ack.

Function
REQ-014 SHALL implement states IDLE, ACCESS, ACCESS2, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL capture all req_* fields when req_valid && req_ready; held stable internally until RESP.
REQ-016 Legal aligned access SHALL go IDLE->ACCESS; mem_req asserted from the next cycle, all mem_* held stable until the cycle mem_ack=1.
REQ-017 On mem_ack in ACCESS (final beat) SHALL go to RESP; rsp_valid=1 for exactly one cycle in RESP, then IDLE; minimum accept-to-rsp_valid latency 2 cycles with zero-wait memory.
REQ-018 mem_be SHALL be 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word); mem_be=0000 when mem_req=0.
REQ-019 mem_wdata SHALL be store data shifted to its lane (byte replicated x4, half replicated x2); unselected lanes don't-care.
REQ-020 Loads SHALL extract the addressed lane(s) from mem_rdata, extend per req_unsigned into rsp_rdata; stores SHALL return rsp_rdata=0.
REQ-021 address_mode=11, or req_addr+size-1 >= 2**ADDR_W, SHALL skip memory: IDLE->RESP, rsp_err=1, rsp_rdata=0.
REQ-022 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; handling per REQ-029/030.
REQ-023 mem_ack while mem_req=0 SHALL be ignored; rsp_valid has no backpressure.
REQ-024 rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 after release.
REQ-026 Reset mid-transaction SHALL abandon it with no response; a pending mem_ack after release is ignored.

Configuration
REQ-027 Macro LSU_MISALIGN_SPLIT_EN SHALL select misaligned handling.
REQ-028 ACCESS2 SHALL exist only when the macro is defined.
REQ-029 Without LSU_MISALIGN_SPLIT_EN: misaligned access SHALL go IDLE->RESP with rsp_err=1, no mem_req.
REQ-030 With LSU_MISALIGN_SPLIT_EN: misaligned access SHALL issue beat 1 at word floor(addr) (ACCESS), then beat 2 at word+4 (ACCESS2) with complementary mem_be; load result merges both beats before extension; response after beat 2 ack.

Structure
REQ-031 Shared package lsu_pkg SHALL hold the address_mode encodings, state enum type, and byte-enable width constant.
REQ-032 Load extraction/extension SHALL be sub-module lsu_load_align (combinational, WIDTH-parameterised).

Verification
REQ-033 Store byte addr=0x0003 data=0x000000A5, ack next cycle -> mem_be=1000, mem_wdata=0xA5A5A5A5, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-034 Load half signed addr=0x0002, mem_rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001; same with req_unsigned=1 -> 0x00008001.
REQ-035 Load word addr=0x0010 with mem_ack delayed 3 cycles -> mem_req/mem_addr=0x0010 held 4 cycles, single rsp_valid pulse, req_ready=0 throughout.
REQ-036 Load word addr=0x0001: without macro -> rsp_err=1, no mem_req; with macro -> beats at 0x0000 (be=1110) and 0x0004 (be=0001), rdata 0x44332211/0x88776655 -> 0x55443322.
REQ-037 address_mode=11, or word at addr=0x1FFFE -> rsp_err=1, rsp_rdata=0, no mem_req.
REQ-038 rst asserted while mem_req=1 -> mem_req=0 same cycle, no rsp_valid, late mem_ack ignored, next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: access-size encodings, FSM state type, byte-enable width.
// The ACCESS2 state only exists when LSU_MISALIGN_SPLIT_EN is defined.
package lsu_pkg;

    localparam int unsigned BE_W = 4;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESP    = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
        , ST_ACCESS2 = 2'd3
`endif
    } lsu_state_e;

    // Unshifted byte-enable pattern for an access size
    function automatic logic [BE_W-1:0] size_mask(input logic [1:0] mode);
        case (mode)
            MODE_BYTE: size_mask = 4'b0001;
            MODE_HALF: size_mask = 4'b0011;
            default:   size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction and sign/zero extension.
// lo_word holds the word at floor(addr); hi_word the following word (only matters for split accesses).
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] lo_word,
    input  logic [WIDTH-1:0] hi_word,
    input  logic [1:0]       offset,
    input  logic [1:0]       mode,
    input  logic             is_unsigned,
    output logic [WIDTH-1:0] data_c
);

    logic [WIDTH-1:0] window;

    // Shift the addressed bytes down to bit 0, then extend per access size
    always_comb begin
        window = WIDTH'({hi_word, lo_word} >> {offset, 3'b000});
        case (mode)
            MODE_BYTE: data_c = {{(WIDTH-8){~is_unsigned & window[7]}}, window[7:0]};
            MODE_HALF: data_c = {{(WIDTH-16){~is_unsigned & window[15]}}, window[15:0]};
            default:   data_c = window;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one core request at a time, translated to word-aligned memory beats.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing misaligned accesses into two beats;
// otherwise misaligned accesses complete immediately with an error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        address_mode,
    input  logic              req_unsigned,
    input  logic [WIDTH-1:0]  req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [WIDTH-1:0]  mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic              op_we_q, op_we_d;
    logic [1:0]        mode_q, mode_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [BE_W-1:0]   be_hi_q, be_hi_d;
    logic [WIDTH-1:0]  beat1_q, beat1_d;
    logic [BE_W-1:0]   be_hi;
`endif

    logic [1:0]        size_m1;
    logic [WIDTH:0]    end_addr;
    logic              out_of_range;
    logic              misaligned;
    logic [BE_W-1:0]   be_lo;
    logic [WIDTH-1:0]  wdata_rep;
    logic [WIDTH-1:0]  wdata_lane;
    logic [WIDTH-1:0]  align_lo;
    logic [WIDTH-1:0]  load_data_c;
    logic              finish;

    // Decode the incoming request: range, alignment, byte enables and lane-placed store data
    always_comb begin
        case (address_mode)
            MODE_BYTE: size_m1 = 2'd0;
            MODE_HALF: size_m1 = 2'd1;
            default:   size_m1 = 2'd3;
        endcase
        end_addr     = {1'b0, req_addr} + (WIDTH+1)'(size_m1);
        out_of_range = |end_addr[WIDTH:ADDR_W];
        misaligned   = ((address_mode == MODE_HALF) && req_addr[0]) ||
                       ((address_mode == MODE_WORD) && (req_addr[1:0] != 2'b00));
        be_lo        = BE_W'(size_mask(address_mode) << req_addr[1:0]);
`ifdef LSU_MISALIGN_SPLIT_EN
        be_hi        = BE_W'(({{BE_W{1'b0}}, size_mask(address_mode)} << req_addr[1:0]) >> BE_W);
`endif
        case (address_mode)
            MODE_BYTE: wdata_rep = {(WIDTH/8){req_wdata[7:0]}};
            MODE_HALF: wdata_rep = {(WIDTH/16){req_wdata[15:0]}};
            default:   wdata_rep = req_wdata;
        endcase
        // Rotate so data byte 0 lands on lane addr[1:0]; wrapped bytes serve a second beat
        wdata_lane   = WIDTH'(({wdata_rep, wdata_rep} << {req_addr[1:0], 3'b000}) >> WIDTH);
    end

    // First-beat word is buffered when a split load is completing
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        align_lo = (state_q == ST_ACCESS2) ? beat1_q : mem_rdata;
`else
        align_lo = mem_rdata;
`endif
    end

    lsu_load_align #(.WIDTH(WIDTH)) u_load_align (
        .lo_word     (align_lo),
        .hi_word     (mem_rdata),
        .offset      (off_q),
        .mode        (mode_q),
        .is_unsigned (uns_q),
        .data_c      (load_data_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        op_we_d     = op_we_q;
        mode_d      = mode_q;
        uns_d       = uns_q;
        off_d       = off_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        be_hi_d     = be_hi_q;
        beat1_d     = beat1_q;
`endif
        finish      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_we_d = req_we;
                    mode_d  = address_mode;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                    be_hi_d = be_hi;
                    if ((address_mode == MODE_ILL) || out_of_range) begin
`else
                    if ((address_mode == MODE_ILL) || out_of_range || misaligned) begin
`endif
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = be_lo;
                        mem_wdata_d = wdata_lane;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    // Only word-crossing accesses need a second beat
                    if (be_hi_q != '0) begin
                        state_d    = ST_ACCESS2;
                        beat1_d    = mem_rdata;
                        mem_addr_d = mem_addr_q + ADDR_W'(BE_W);
                        mem_be_d   = be_hi_q;
                    end else begin
                        finish = 1'b1;
                    end
`else
                    finish = 1'b1;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ACCESS2: begin
                if (mem_ack) begin
                    finish = 1'b1;
                end
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d     = ST_RESP;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_be_d    = '0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = op_we_q ? '0 : load_data_c;
        end
    end

    // Ready is registered from the next state so it is high exactly while in IDLE
    assign req_ready_d = (state_d == ST_IDLE);

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            op_we_q     <= 1'b0;
            mode_q      <= MODE_BYTE;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
`ifdef LSU_MISALIGN_SPLIT_EN
            be_hi_q     <= '0;
            beat1_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            op_we_q     <= op_we_d;
            mode_q      <= mode_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            be_hi_q     <= be_hi_d;
            beat1_q     <= beat1_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit (default build: misaligned accesses fault).
module tb_load_store_unit;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 17;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        address_mode;
    logic              req_unsigned;
    logic [WIDTH-1:0]  req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_ack;
    logic [WIDTH-1:0]  mem_rdata;

    load_store_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .address_mode (address_mode),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  mode;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        int          beats;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, play the memory with the vector's ack delay, check every observable
    task automatic run_vec(input vec_t v, input string tag);
        int  c;
        int  req_cycles;
        int  wait_cnt;
        int  exp_lat;
        bit  done;
        @(negedge clk);
        chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = v.we;
        address_mode = v.mode;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(negedge clk);
        req_valid    = 1'b0;
        req_we       = ~v.we;
        address_mode = 2'b11;
        req_unsigned = ~v.uns;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = 32'h5A5A_5A5A;
        exp_lat      = (v.beats == 0) ? 1 : 1 + v.beats * (v.delay + 1);
        done = 1'b0;
        c = 0;
        req_cycles = 0;
        wait_cnt = 0;
        while (!done && c < 40) begin
            c++;
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            if (rsp_valid) begin
                done = 1'b1;
                chk({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
                chk({tag, ".err"}, 32'(rsp_err), 32'(v.exp_err));
                chk({tag, ".latency"}, 32'(c), 32'(exp_lat));
                chk({tag, ".mem_req_cycles"}, 32'(req_cycles), 32'(v.beats * (v.delay + 1)));
            end else begin
                chk({tag, ".err_quiet"}, 32'(rsp_err), 32'd0);
                chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
                if (mem_req) begin
                    req_cycles++;
                    chk({tag, ".mem_addr"}, 32'(mem_addr), v.exp_addr);
                    chk({tag, ".mem_be"}, 32'(mem_be), 32'(v.exp_be));
                    chk({tag, ".mem_we"}, 32'(mem_we), 32'(v.we));
                    if (v.we) chk({tag, ".mem_wdata"}, mem_wdata, v.exp_wdata);
                    if (wait_cnt == v.delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = v.rdata;
                        wait_cnt  = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    chk({tag, ".be_idle"}, 32'(mem_be), 32'd0);
                end
                @(negedge clk);
            end
        end
        chk({tag, ".completed"}, 32'(done), 32'd1);
        mem_ack = 1'b0;
        @(negedge clk);
        chk({tag, ".single_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we mode   uns addr          wdata         dly rdata         beats exp_addr      be       exp_wdata     exp_rdata     err
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0000_00A5, 0, 32'h0,         1, 32'h0000_0000, 4'b1000, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,         0, 32'h8001_1234, 1, 32'h0000_0000, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,         0, 32'h8001_1234, 1, 32'h0000_0000, 4'b1100, 32'h0,         32'h0000_8001, 1'b0};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         3, 32'hCAFE_BABE, 1, 32'h0000_0010, 4'b1111, 32'h0,         32'hCAFE_BABE, 1'b0};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0,         0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 32'h0000_0004, 32'h1111_2222, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0001_FFFE, 32'h0,         0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h0001_FFFF, 32'h0,         1, 32'h9A00_0000, 1, 32'h0001_FFFC, 4'b1000, 32'h0,         32'hFFFF_FF9A, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0001_FFFC, 32'h0,         2, 32'h0102_0304, 1, 32'h0001_FFFC, 4'b1111, 32'h0,         32'h0102_0304, 1'b0};
        vecs[9]  = '{1'b0, 2'b00, 1'b1, 32'h0002_0000, 32'h0,         0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0,         0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_BEEF, 1, 32'h0,         1, 32'h0000_0000, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0};
        vecs[12] = '{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1234_5678, 0, 32'hFFFF_FFFF, 1, 32'h0000_0008, 4'b1111, 32'h1234_5678, 32'h0,         1'b0};
        vecs[13] = '{1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0,         0, 32'h0000_F000, 1, 32'h0000_0000, 4'b0010, 32'h0,         32'h0000_00F0, 1'b0};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,         0, 32'h0000_F000, 1, 32'h0000_0000, 4'b0010, 32'h0,         32'hFFFF_FFF0, 1'b0};
        vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h0001_FFFE, 32'h0,         0, 32'h7FFF_0000, 1, 32'h0001_FFFC, 4'b1100, 32'h0,         32'h0000_7FFF, 1'b0};
        vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0,         0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        address_mode = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        repeat (3) @(negedge clk);
        chk("rst.mem_req",   32'(mem_req),   32'd0);
        chk("rst.mem_we",    32'(mem_we),    32'd0);
        chk("rst.mem_be",    32'(mem_be),    32'd0);
        chk("rst.mem_addr",  32'(mem_addr),  32'd0);
        chk("rst.mem_wdata", mem_wdata,      32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_err",   32'(rsp_err),   32'd0);
        chk("rst.rsp_rdata", rsp_rdata,      32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while a load is waiting on memory: abandoned, no response, late ack ignored
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        address_mode = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0020;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_rst.mem_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("mid_rst.mem_req_held", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst.mem_req_async", 32'(mem_req), 32'd0);
        chk("mid_rst.mem_be_async",  32'(mem_be),  32'd0);
        chk("mid_rst.rsp_valid",     32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mid_rst.no_rsp%0d", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("mid_rst.no_req%0d", k), 32'(mem_req),   32'd0);
            chk($sformatf("mid_rst.ready%0d", k),  32'(req_ready), 32'd1);
            @(negedge clk);
        end
        run_vec(vecs[3], "post_rst_load");
        run_vec(vecs[0], "post_rst_store");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
